// File: rtl/ntt257_pkg.sv
// Shared constants and mod-257 arithmetic for the NTT datapath.
// All residues are canonical 9-bit values in 0..256.
package ntt257_pkg;

  localparam int unsigned Q       = 257;
  localparam logic [8:0]  W64_INV = 9'd165;
  localparam logic [8:0]  W8_INV  = 9'd253;
  localparam logic [8:0]  N_INV   = 9'd253;

  typedef enum logic [1:0] {
    IDLE,
    PASS1,
    PASS2,
    DONE
  } state_t;

  // 256 == -1 (mod 257), so p = lo + 256*hi reduces to lo - hi.
  function automatic logic [8:0] modred(input logic [16:0] p);
    logic signed [9:0] r;
    r = $signed({2'b00, p[7:0]}) - $signed({1'b0, p[16:8]});
    if (r < 10'sd0) r = r + 10'sd257;
    else if (r >= 10'sd257) r = r - 10'sd257;
    return r[8:0];
  endfunction

  function automatic logic [8:0] modmul(input logic [8:0] a, input logic [8:0] b);
    logic [16:0] p;
    p = 17'(a) * 17'(b);
    return modred(p);
  endfunction

  function automatic logic [8:0] modadd(input logic [8:0] a, input logic [8:0] b);
    logic [9:0] s;
    s = 10'(a) + 10'(b);
    if (s >= 10'(Q)) s = s - 10'(Q);
    return s[8:0];
  endfunction

  function automatic logic [8:0] modneg(input logic [8:0] a);
    return (a == '0) ? '0 : 9'(Q) - a;
  endfunction

  // Signed 10-bit input (-512..511) to canonical residue.
  function automatic logic [8:0] canon_in(input logic [9:0] x);
    logic signed [11:0] t;
    t = {{2{x[9]}}, x};
    if (x[9]) t = t + 12'sd514;
    if (t >= 12'sd257) t = t - 12'sd257;
    return t[8:0];
  endfunction

  // W64_INV^(8q+r) = W8_INV^q * W64_INV^r
  function automatic logic [7:0][7:0][8:0] tw_gen();
    logic [7:0][7:0][8:0] t;
    logic [8:0]           p;
    t = '0;
    for (int unsigned n1 = 0; n1 < 8; n1++) begin
      for (int unsigned k2 = 0; k2 < 8; k2++) begin
        p = 9'd1;
        for (int unsigned e = 0; e < (n1 * k2) / 8; e++) p = modmul(p, W8_INV);
        for (int unsigned e = 0; e < (n1 * k2) % 8; e++) p = modmul(p, W64_INV);
        t[n1][k2] = p;
      end
    end
    return t;
  endfunction

  localparam logic [7:0][7:0][8:0] TW_INV = tw_gen();

endpackage

// File: rtl/ifft_8_mod.sv
// Combinational 8-point inverse NTT mod 257 with root -4.
// Powers of -4 are a shift by 0/2/4/6 plus an optional negation.
module ifft_8_mod
  import ntt257_pkg::*;
(
  input  logic [7:0][8:0] x,
  output logic [7:0][8:0] y
);

  // (-4)^e: magnitude 2^(2*e[1:0]); sign flips on odd e and again for e>=4 (4^4 == -1).
  function automatic logic [8:0] mul_root_pow(input logic [8:0] a, input logic [2:0] e);
    logic [16:0] s;
    logic [8:0]  r;
    s = 17'(a) << {e[1:0], 1'b0};
    r = modred(s);
    return (e[0] ^ e[2]) ? modneg(r) : r;
  endfunction

  logic [8:0] acc;

  always_comb begin
    y   = '0;
    acc = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      acc = '0;
      for (int unsigned n = 0; n < 8; n++)
        acc = modadd(acc, mul_root_pow(x[n], 3'((n * k) % 8)));
      y[k] = acc;
    end
  end

endmodule

// File: rtl/ifft_64.sv
// Iterative 64-point inverse NTT mod 257: one radix-8 core swept over
// 8 columns in each of two passes, start/busy/done handshake.
module ifft_64
  import ntt257_pkg::*;
#(
  parameter int unsigned ELEM_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [64*ELEM_W-1:0]  yi,
  output logic                  busy,
  output logic                  done,
  output logic [64*ELEM_W-1:0]  yo
);

  state_t          state, state_nx;
  logic [2:0]      cnt;
  logic [8:0]      mem [64];
  logic [7:0][5:0] col_idx;
  logic [7:0][8:0] col_in;
  logic [7:0][8:0] col_out;
  logic [7:0][8:0] col_tw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = PASS1;
      end
      PASS1:   if (cnt == 3'd7) state_nx = PASS2;
      PASS2:   if (cnt == 3'd7) state_nx = DONE;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pass 1 walks column n1=cnt (index n1+8*j); pass 2 walks column k2=cnt (index j+8*k2).
  // Results go back to the slots they were read from, so one index serves read and write.
  always_comb begin
    col_idx = '0;
    col_in  = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      col_idx[j] = (state == PASS1) ? {3'(j), cnt} : {cnt, 3'(j)};
      col_in[j]  = mem[col_idx[j]];
    end
  end

  ifft_8_mod u_core (
    .x (col_in),
    .y (col_out)
  );

  always_comb begin
    col_tw = '0;
    for (int unsigned j = 0; j < 8; j++)
      col_tw[j] = modmul(col_out[j], (state == PASS1) ? TW_INV[cnt][j] : N_INV);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      for (int unsigned i = 0; i < 64; i++) mem[6'(i)] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
            for (int unsigned i = 0; i < 64; i++)
              mem[6'(i)] <= canon_in(yi[ELEM_W*i +: ELEM_W]);
          end
        end
        PASS1, PASS2: begin
          cnt <= cnt + 3'd1;
          for (int unsigned j = 0; j < 8; j++) mem[col_idx[j]] <= col_tw[j];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    yo = '0;
    for (int unsigned k1 = 0; k1 < 8; k1++)
      for (int unsigned k2 = 0; k2 < 8; k2++)
        yo[ELEM_W*(8*k1 + k2) +: ELEM_W] = ELEM_W'(mem[6'(k1 + 8*k2)]);
  end

endmodule

// File: tb/tb_ifft_64.sv
// Bench for ifft_64: directed vector table, handshake/reset sequences and
// random vectors against a direct 64-point DFT mod 257.
module tb_ifft_64;

  localparam int unsigned EW = 10;
  localparam int unsigned VW = 64 * EW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [VW-1:0] yi;
  logic          busy;
  logic          done;
  logic [VW-1:0] yo;

  always #5 clk = ~clk;

  ifft_64 #(.ELEM_W(EW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .yi    (yi),
    .busy  (busy),
    .done  (done),
    .yo    (yo)
  );

  int            checks = 0;
  int            errors = 0;
  logic [VW-1:0] sb_q[$];
  int            pw[64];

  typedef struct {
    string         name;
    logic [VW-1:0] vin;
    logic [VW-1:0] vexp;
  } vec_t;

  vec_t tbl[7];

  function automatic logic [VW-1:0] splat(input logic [EW-1:0] e);
    logic [VW-1:0] v;
    for (int k = 0; k < 64; k++) v[EW*k +: EW] = e;
    return v;
  endfunction

  // Direct O(N^2) transform: X[k] = 253 * sum_n x[n]*165^(nk) mod 257.
  function automatic logic [VW-1:0] model(input logic [VW-1:0] v);
    int            c[64];
    int            acc;
    logic [VW-1:0] r;
    for (int n = 0; n < 64; n++) begin
      c[n] = int'($signed(v[EW*n +: EW]));
      c[n] = ((c[n] % 257) + 257) % 257;
    end
    r = '0;
    for (int k = 0; k < 64; k++) begin
      acc = 0;
      for (int n = 0; n < 64; n++) acc = (acc + c[n] * pw[(n * k) % 64]) % 257;
      acc = (acc * 253) % 257;
      r[EW*k +: EW] = EW'(acc);
    end
    return r;
  endfunction

  task automatic chk_int(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, $signed(act), $signed(exp_v));
    end
  endtask

  task automatic chk_vec(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      for (int k = 0; k < 64; k++) begin
        if (act[EW*k +: EW] !== exp_v[EW*k +: EW]) begin
          $display("FAIL %s: yo[%0d] got %0d want %0d", nm, k, act[EW*k +: EW], exp_v[EW*k +: EW]);
          break;
        end
      end
    end
  endtask

  // Called at a negedge while idle; returns at the negedge after the accept edge.
  task automatic launch(input logic [VW-1:0] v, input logic [VW-1:0] e);
    yi    = v;
    start = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_run(input string nm);
    int            lat;
    logic [VW-1:0] exp_v;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk_int({nm, " latency"}, lat, 16);
    if (lat > 0) begin
      exp_v = sb_q.pop_front();
      chk_vec(nm, yo, exp_v);
      chk_int({nm, " busy@done"}, busy, 1);
      @(negedge clk);
      chk_int({nm, " done drops"}, done, 0);
      chk_vec({nm, " hold"}, yo, exp_v);
    end else if (sb_q.size() > 0) begin
      void'(sb_q.pop_front());
    end
  endtask

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] v;
    logic [VW-1:0] e;
    int            first, second, pulses;

    pw[0] = 1;
    for (int i = 1; i < 64; i++) pw[i] = (pw[i-1] * 165) % 257;

    tbl[0].name = "impulse";    tbl[0].vin = '0; tbl[0].vin[9:0] = 10'd1;
    tbl[0].vexp = splat(10'd253);
    tbl[1].name = "constant";   tbl[1].vin = splat(10'd1);
    tbl[1].vexp = '0; tbl[1].vexp[9:0] = 10'd1;
    tbl[2].name = "shift_imp";  tbl[2].vin = '0; tbl[2].vin[19:10] = 10'd1;
    tbl[2].vexp = '0;
    for (int k = 0; k < 64; k++) tbl[2].vexp[EW*k +: EW] = EW'((253 * pw[k]) % 257);
    tbl[3].name = "all_neg1";   tbl[3].vin = splat(10'h3FF);
    tbl[3].vexp = '0; tbl[3].vexp[9:0] = 10'd256;
    tbl[4].name = "neg257";     tbl[4].vin = '0; tbl[4].vin[9:0] = 10'h2FF;
    tbl[4].vexp = '0;
    tbl[5].name = "max_pos";    tbl[5].vin = '0; tbl[5].vin[9:0] = 10'd511;
    tbl[5].vexp = splat(10'd12);
    tbl[6].name = "min_neg";    tbl[6].vin = '0; tbl[6].vin[9:0] = 10'h200;
    tbl[6].vexp = splat(10'd249);

    rst   = 1'b1;
    start = 1'b1;
    yi    = '1;
    repeat (3) @(negedge clk);
    chk_int("reset busy", busy, 0);
    chk_int("reset done", done, 0);
    chk_vec("reset yo", yo, '0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 7; t++) begin
      launch(tbl[t].vin, tbl[t].vexp);
      finish_run(tbl[t].name);
    end

    // start held high: accepts at E0 and E18, never in the DONE cycle
    yi     = tbl[0].vin;
    start  = 1'b1;
    first  = -1;
    second = -1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
        chk_int("held busy@done", busy, 1);
        chk_vec("held yo", yo, tbl[0].vexp);
      end
      if (i == 17) chk_int("held idle gap", busy, 0);
    end
    start = 1'b0;
    chk_int("held pulses", pulses, 2);
    chk_int("held first", first, 16);
    chk_int("held spacing", second - first, 18);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // abort in PASS2, then restart in the first cycle after reset release
    yi    = tbl[2].vin;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    chk_int("abort early done", pulses, 0);
    rst = 1'b1;
    #1;
    chk_int("abort busy", busy, 0);
    chk_int("abort done", done, 0);
    chk_vec("abort yo", yo, '0);
    @(negedge clk);
    rst = 1'b0;
    launch(tbl[5].vin, tbl[5].vexp);
    finish_run("post_abort");

    for (int r = 0; r < 1000; r++) begin
      for (int k = 0; k < 64; k++) v[EW*k +: EW] = EW'($urandom_range(0, 1023));
      e = model(v);
      launch(v, e);
      finish_run("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
